demux_1to4_stream: RTL
======================

// Module: demux_1to4_stream
// PURPOSE
//  Registered 1-to-4 stream demultiplexer with valid/ready handshake: the distributing counterpart of
//  the 4:1 select mux. One producer stream is routed by a per-beat 2-bit select to one of four consumer
//  streams. Each output has a 2-entry FIFO so producer and consumers decouple. Used to fan results out
//  to writeback/forwarding consumers in the pipeline.
// PARAMETERS
//  WORD_SIZE  32  data width of input and of each output lane, bits
// PORTS
//  clk        in   1            single clock, all state updates on rising edge
//  rst        in   1            synchronous reset, active-high
//  in_valid   in   1            producer beat valid
//  in_ready   out  1            demux accepts beat this cycle
//  in_sel     in   2            destination lane 0..3 (00=a,01=b,10=c,11=d); sampled with beat
//  in_data    in   WORD_SIZE    producer data
//  out_valid  out  4            lane i holds a beat (bit i)
//  out_ready  in   4            consumer i accepts beat (bit i)
//  out_data   out  4*WORD_SIZE  lane i data at [i*WORD_SIZE +: WORD_SIZE]
// BEHAVIOUR
//  - Per lane: 2-entry FIFO (entries e0/e1, 1-bit wr/rd pointers, 2-bit count 0..2).
//  - Reset (rst=1 at edge): all counts=0, pointers=0; out_valid=4'b0000; in_ready=1; out_data=0.
//  - in_ready = (count[in_sel] != 2); combinational from registered count and in_sel only;
//    never depends on out_ready (no comb path out_ready->in_ready).
//  - Push: in_valid & in_ready -> in_data written to lane in_sel at wr_ptr; wr_ptr toggles.
//  - Pop lane i: out_valid[i] & out_ready[i] -> rd_ptr[i] toggles; count[i] decrements.
//  - out_valid[i] = (count[i] != 0); out_data lane i = entry at rd_ptr[i] (registered storage).
//  - Latency: beat accepted at edge N is visible on out_valid/out_data at N+1 (1 cycle).
//  - Simultaneous push+pop same lane: count unchanged; both legal when count=1. At count=2 push is
//    blocked (in_ready=0) even if that lane pops same cycle; accepted next cycle.
//  - Pops on different lanes and push to any lane all proceed independently in one cycle.
//  - Ordering: beats to the same lane exit in acceptance order; no ordering across lanes.
//  - Stall on one full lane blocks only beats selecting that lane (producer must hold beat stable
//    per valid/ready rule: in_valid, in_sel, in_data held until in_ready).
//  - out_valid[i] once high stays high, data stable, until popped.
//  - Pointer wrap: 1-bit pointers wrap 1->0 naturally; count alone decides full/empty.
//  - out_ready[i] while out_valid[i]=0: ignored, no state change.
//  - Reset mid-operation: all buffered beats discarded, outputs return to reset values next cycle.
// CONFIGURATION
//  DEMUX_BCAST_EN: adds input port in_bcast (1 bit).
//   defined: in_bcast=1 copies the beat into all four lanes; in_sel ignored;
//     in_ready = all four counts != 2; push occurs in all lanes at the same edge.
//     in_bcast=0 behaves exactly as the base mode.
//   undefined: port absent; unicast only.
// TESTING
//  1 reset: assert rst 2 cycles -> out_valid=0000, in_ready=1, out_data=0.
//  2 unicast: push 0xDEADBEEF sel=2, out_ready=0000 -> next cycle out_valid=0100,
//    lane2 data=0xDEADBEEF; other lanes unchanged.
//  3 full/backpressure: 3 beats 0x1,0x2,0x3 sel=1, out_ready=0 -> first two accepted,
//    in_ready=0 on 3rd; beat sel=0 still accepted; then out_ready[1]=1 -> lane1 pops 0x1,0x2, then 0x3.
//  4 push+pop same lane: lane 3 count=1, push 0xA5 and pop same cycle -> count stays 1, order kept.
//  5 reset mid-op: lanes 0..3 hold beats, rst=1 one cycle -> out_valid=0000, in_ready=1.
//  6 DEMUX_BCAST_EN: in_bcast=1 data 0x55 -> all out_valid=1111 with 0x55; lane0 full -> in_ready=0.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// ---------------------------------------------------------------------------
// demux_1to4_stream
//
// Registered 1-to-4 stream demultiplexer with valid/ready handshakes. Each
// producer beat is routed by its 2-bit select to one of four consumer lanes.
// Every lane buffers beats in its own 2-entry FIFO, so a stalled consumer
// only blocks beats that select its lane.
//
// Optional feature (compile-time macro DEMUX_BCAST_EN):
//   adds input in_bcast; a beat with in_bcast=1 is copied into all four
//   lanes at the same edge and in_sel is ignored.
//
// Parameters
//   WORD_SIZE   data width of the input and of each output lane
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous reset, active-high
//   in_valid    producer beat valid
//   in_ready    demux accepts the beat this cycle
//   in_sel      destination lane 0..3 (00=a, 01=b, 10=c, 11=d)
//   in_data     producer data
//   in_bcast    (DEMUX_BCAST_EN only) copy the beat into all lanes
//   out_valid   bit i: lane i holds a beat
//   out_ready   bit i: consumer i accepts the beat
//   out_data    lane i data at [i*WORD_SIZE +: WORD_SIZE]
// ---------------------------------------------------------------------------
module demux_1to4_stream #(
    parameter int WORD_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_sel,
    input  logic [WORD_SIZE-1:0]   in_data,
`ifdef DEMUX_BCAST_EN
    input  logic                   in_bcast,
`endif
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [4*WORD_SIZE-1:0] out_data
);

    // Per-lane FIFO state: two entries, 1-bit pointers, occupancy 0..2.
    logic [WORD_SIZE-1:0] mem [4][2];
    logic [3:0]           wr_ptr;
    logic [3:0]           rd_ptr;
    logic [1:0]           count [4];

    logic [3:0]           lane_full;
    logic [3:0]           push;
    logic [3:0]           pop;
    logic                 bcast;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // in_ready depends only on registered occupancy and the beat's own
    // routing, never on out_ready: a lane that is full but popping this
    // cycle still refuses the push, and accepts it on the next cycle.
    always_comb begin
        // NOTE: every signal driven in always_comb gets a default first so
        // no path through the block leaves it unassigned (no latch).
        lane_full = '0;
        push      = '0;
        pop       = '0;
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            lane_full[i] = (count[i] == 2'd2);
            out_valid[i] = (count[i] != 2'd0);
            out_data[i*WORD_SIZE +: WORD_SIZE] = mem[i][rd_ptr[i]];
        end

        in_ready = bcast ? ~(|lane_full) : ~lane_full[in_sel];

        for (int i = 0; i < 4; i++) begin
            push[i] = in_valid & in_ready & (bcast | (in_sel == 2'(i)));
            // out_ready on an empty lane is ignored.
            pop[i]  = out_valid[i] & out_ready[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: the two-entry storage is reset as well, because the
                // head entry drives out_data directly and must read 0 after
                // reset; this is cheap at this depth.
                mem[g][0] <= '0;
                mem[g][1] <= '0;
                wr_ptr[g] <= 1'b0;
                rd_ptr[g] <= 1'b0;
                count[g]  <= 2'd0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so all
                // lanes see the pre-edge values of every register.
                if (push[g]) begin
                    mem[g][wr_ptr[g]] <= in_data;
                    wr_ptr[g]         <= ~wr_ptr[g];
                end
                if (pop[g]) begin
                    rd_ptr[g] <= ~rd_ptr[g];
                end
                // Simultaneous push and pop leaves the occupancy unchanged.
                case ({push[g], pop[g]})
                    2'b10:   count[g] <= count[g] + 2'd1;
                    2'b01:   count[g] <= count[g] - 2'd1;
                    default: count[g] <= count[g];
                endcase
            end
        end
    end

endmodule
